fp_accum: RTL and testbench

- Sequential IEEE-754 single-precision accumulator directly downstream of fp_mult.
- Consumes a stream of product words through a valid/ready handshake and adds each into a running sum.
- On the beat flagged last, it emits the final sum and re-arms at +0.
- Turns fp_mult into a dot-product / MAC datapath. One add in flight at a time; fixed 4-cycle beat.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_accum.sv | 246 ++++++++++++++++++++++++
 tb/tb_fp_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision accumulator: format constants,
// special encodings, FSM state names and field helpers.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_ADD   = 2'd2,
    S_NORM  = 2'd3
  } state_e;

  // Outcome classes resolved during ALIGN that bypass the mantissa path.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2
  } special_e;

  function automatic logic f_sign(input logic [WORD_W-1:0] w);
    return w[WORD_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [WORD_W-1:0] w);
    return w[WORD_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [WORD_W-1:0] w);
    return w[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W  = 25,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Sequential single-precision accumulator: one add in flight, four-cycle beat
// (IDLE accept, ALIGN, ADD, NORM). The group sum is emitted on the last beat.
module fp_accum #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   in_last,
  input  logic                   clear,
  output logic                   acc_valid,
  output logic [EXP_W+MAN_W:0]   acc_data,
  output logic                   overflow,
  output logic                   busy
);

  import fp_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;          // mantissa with hidden bit
  localparam int XW = MW + 3;             // mantissa plus guard/round/sticky
  localparam int LW = MW + 1;             // span searched for the leading one
  localparam int CW = $clog2(LW + 1);
  localparam int EW = EXP_W + 2;          // signed exponent headroom

  localparam logic [EXP_W-1:0]    EXP_MAX = '1;
  localparam logic [W-1:0]        NAN_W   = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_INF  = EW'((1 << EXP_W) - 1);

  state_e state_q, state_d;

  logic [W-1:0] sum_q, opnd_q, acc_data_q;
  logic         last_q, first_q, acc_valid_q, ovf_q;

  // ALIGN results, stable through ADD and NORM since only one beat is in flight
  logic               sa_q, sub_q, sp_sign_q;
  logic [EXP_W-1:0]   ea_q;
  logic [XW-1:0]      ma_q, mb_q;
  special_e           sp_q;

  // ADD result: carry bit on top of the G/R/S-extended mantissa
  logic [XW:0]        res_q;

  logic accept;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_ready & in_valid & ~clear;
  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;
  assign overflow  = ovf_q;

  // State register; clear aborts the beat from any state.
  always_ff @(posedge clk) begin
    if (!rst_n)     state_q <= S_IDLE;
    else if (clear) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Fixed walk through the stages once a beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- ALIGN: unpack, flush denormals, order by magnitude, shift B ----
  logic             xs, ys, as_c, bs_c, swap;
  logic [EXP_W-1:0] xe, ye, ae_c, be_c, diff;
  logic [MAN_W-1:0] xm, ym;
  logic [MW-1:0]    xmant, ymant, am_c, bm_c;
  logic [W-2:0]     xmag, ymag;
  logic [XW-1:0]    bx, lost_mask, mb_c;
  logic             x_nan, y_nan, x_inf, y_inf;
  special_e         sp_c;
  logic             sp_sign_c;

  // Operand preparation for the add; sum_q is the running A side.
  always_comb begin
    xs = sum_q[W-1];   xe = sum_q[W-2:MAN_W];   xm = sum_q[MAN_W-1:0];
    ys = opnd_q[W-1];  ye = opnd_q[W-2:MAN_W];  ym = opnd_q[MAN_W-1:0];

    x_nan = (xe == EXP_MAX) && (xm != '0);
    y_nan = (ye == EXP_MAX) && (ym != '0);
    x_inf = (xe == EXP_MAX) && (xm == '0);
    y_inf = (ye == EXP_MAX) && (ym == '0);

    xmant = (xe == '0) ? '0 : {1'b1, xm};
    ymant = (ye == '0) ? '0 : {1'b1, ym};
    xmag  = {xe, (xe == '0) ? {MAN_W{1'b0}} : xm};
    ymag  = {ye, (ye == '0) ? {MAN_W{1'b0}} : ym};

    swap = (ymag > xmag);
    as_c = swap ? ys    : xs;
    bs_c = swap ? xs    : ys;
    ae_c = swap ? ye    : xe;
    be_c = swap ? xe    : ye;
    am_c = swap ? ymant : xmant;
    bm_c = swap ? xmant : ymant;

    diff      = ae_c - be_c;
    bx        = {bm_c, 3'b000};
    lost_mask = '0;
    if (diff >= EXP_W'(XW)) begin
      mb_c = {{(XW-1){1'b0}}, |bm_c};
    end else begin
      lost_mask = ~({XW{1'b1}} << diff);
      mb_c      = (bx >> diff) | {{(XW-1){1'b0}}, |(bx & lost_mask)};
    end

    sp_c      = SP_NONE;
    sp_sign_c = 1'b0;
    if (x_nan || y_nan) begin
      sp_c = SP_NAN;
    end else if (x_inf && y_inf) begin
      sp_c      = (xs != ys) ? SP_NAN : SP_INF;
      sp_sign_c = xs;
    end else if (x_inf) begin
      sp_c      = SP_INF;
      sp_sign_c = xs;
    end else if (y_inf) begin
      sp_c      = SP_INF;
      sp_sign_c = ys;
    end
  end

  // ---- ADD: magnitude add or subtract; |A| >= |B| keeps it non-negative ----
  logic [XW:0] add_c;

  // Effective operation follows the operand signs.
  always_comb begin
    if (sub_q) add_c = {1'b0, ma_q} - {1'b0, mb_q};
    else       add_c = {1'b0, ma_q} + {1'b0, mb_q};
  end

  // ---- NORM: normalise, round to nearest even, pack ----
  logic [CW-1:0]          lz;
  logic [XW-1:0]          m_n;
  logic [MW:0]            m_r;
  logic [MAN_W-1:0]       frac;
  logic signed [EW-1:0]   e_pre, e_fin;
  logic                   rnd_inc, ovf_set;
  logic [W-1:0]           result;

  // After a subtraction the leading one never falls below the guard bit.
  fp_lzc #(.W(LW)) u_lzc (
    .d_i   (res_q[XW-1:2]),
    .cnt_o (lz)
  );

  // Normalise the raw sum and resolve specials, overflow and underflow.
  always_comb begin
    if (res_q[XW]) begin
      m_n   = {res_q[XW:2], res_q[1] | res_q[0]};
      e_pre = $signed({2'b00, ea_q}) + E_ONE;
    end else begin
      m_n   = res_q[XW-1:0] << lz;
      e_pre = $signed({2'b00, ea_q}) - $signed({{(EW-CW){1'b0}}, lz});
    end

    rnd_inc = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    m_r     = {1'b0, m_n[XW-1:3]} + {{MW{1'b0}}, rnd_inc};
    frac    = m_r[MW] ? m_r[MAN_W:1] : m_r[MAN_W-1:0];
    e_fin   = e_pre + $signed({{(EW-1){1'b0}}, m_r[MW]});

    ovf_set = 1'b0;
    result  = '0;
    case (sp_q)
      SP_NAN:  result = NAN_W;
      SP_INF:  result = {sp_sign_q, EXP_MAX, {MAN_W{1'b0}}};
      default: begin
        if (res_q == '0) begin
          result = '0;
        end else if (e_fin >= E_INF) begin
          result  = {sa_q, EXP_MAX, {MAN_W{1'b0}}};
          ovf_set = 1'b1;
        end else if (e_fin < E_ONE) begin
          result = '0;
        end else begin
          result = {sa_q, e_fin[EXP_W-1:0], frac};
        end
      end
    endcase
  end

  // Datapath registers: operand capture, ALIGN and ADD results.
  always_ff @(posedge clk) begin
    if (accept) opnd_q <= in_data;
    if (state_q == S_ALIGN) begin
      sa_q      <= as_c;
      sub_q     <= as_c ^ bs_c;
      ea_q      <= ae_c;
      ma_q      <= {am_c, 3'b000};
      mb_q      <= mb_c;
      sp_q      <= sp_c;
      sp_sign_q <= sp_sign_c;
    end
    if (state_q == S_ADD) res_q <= add_c;
  end

  // Running sum, group bookkeeping and the result/overflow outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      acc_data_q  <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
    end else if (clear) begin
      sum_q       <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      if (accept) begin
        last_q  <= in_last;
        first_q <= 1'b0;
        if (first_q) ovf_q <= 1'b0;
      end
      if (state_q == S_NORM) begin
        if (ovf_set) ovf_q <= 1'b1;
        if (last_q) begin
          acc_data_q  <= result;
          acc_valid_q <= 1'b1;
          sum_q       <= '0;
          first_q     <= 1'b1;
        end else begin
          sum_q <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Bench for fp_accum: directed cases plus random groups against a real-valued
// reference that rounds each partial sum to single precision.
module tb_fp_accum;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_last, clear;
  logic        acc_valid, overflow, busy;
  logic [31:0] in_data, acc_data;

  int checks = 0, errors = 0, pulses = 0, exp_pulses = 0;
  logic [31:0] grp[$];
  logic [31:0] last_acc = 32'h0;

  always #5 clk = ~clk;

  fp_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .acc_valid(acc_valid), .acc_data(acc_data), .overflow(overflow), .busy(busy)
  );

  always @(negedge clk) if (acc_valid === 1'b1) pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_nan(input logic [31:0] w);
    return (f_exp(w) == 8'hFF) && (f_man(w) != 0);
  endfunction

  function automatic logic is_inf(input logic [31:0] w);
    return (f_exp(w) == 8'hFF) && (f_man(w) == 0);
  endfunction

  function automatic real f2r(input logic [31:0] w);
    int  e;
    real m;
    e = int'(f_exp(w));
    if (e == 0) return 0.0;
    m = real'({1'b1, f_man(w)}) * (2.0 ** real'(e - BIAS - MAN_W));
    return f_sign(w) ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r, output logic ovf);
    logic [63:0] b;
    logic [52:0] mant;
    logic [24:0] q;
    logic [28:0] rem;
    int          es;
    ovf = 1'b0;
    if (r == 0.0) return 32'h0;
    b    = $realtobits(r);
    es   = int'(b[62:52]) - 1023 + BIAS;
    mant = {1'b1, b[51:0]};
    q    = {1'b0, mant[52:29]};
    rem  = mant[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && q[0])) q = q + 25'd1;
    if (q[24]) begin q = q >> 1; es++; end
    if (es >= 255) begin ovf = 1'b1; return {b[63], 8'hFF, 23'h0}; end
    if (es < 1) return 32'h0;
    return {b[63], es[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b,
                                            output logic ovf);
    ovf = 1'b0;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] != b[31]) ? QNAN : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    return r2f(f2r(a) + f2r(b), ovf);
  endfunction

  task automatic model_group(output logic [31:0] s, output logic o);
    logic t;
    s = 32'h0;
    o = 1'b0;
    foreach (grp[i]) begin
      s = add_model(s, grp[i], t);
      o = o | t;
    end
  endtask

  function automatic logic [31:0] rnd_word(input logic [31:0] prev);
    logic [31:0] sp [8] = '{32'h0, 32'h8000_0000, 32'h0000_0001, POS_INF,
                            NEG_INF, QNAN, 32'h7F7F_FFFF, 32'hFF7F_FFFF};
    int k;
    k = $urandom_range(0, 11);
    if (k == 0) return sp[$urandom_range(0, 7)];
    if (k == 1) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    if (k <= 4 && prev != 0) return prev ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
    return {1'($urandom), 8'($urandom_range(118, 134)), 23'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  task automatic beat(input logic [31:0] d, input logic last, input logic first,
                      input string tag, input logic [31:0] es, input logic eo);
    int n;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
    if (first) chk({tag, "_ovfclr"}, 32'(overflow), 32'd0);
    n = 0;
    while (in_ready !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_vld"}, 32'(acc_valid), 32'(last));
    if (last) begin
      chk({tag, "_sum"}, acc_data, es);
      chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(acc_valid), 32'd0);
      chk({tag, "_hold"}, acc_data, es);
      chk({tag, "_ovfhold"}, 32'(overflow), 32'(eo));
    end
  endtask

  task automatic run_group(input string tag, input logic [31:0] es, input logic eo);
    for (int i = 0; i < grp.size(); i++)
      beat(grp[i], (i == grp.size() - 1), (i == 0), tag, es, eo);
    exp_pulses++;
    last_acc = es;
  endtask

  initial begin
    logic [31:0] ms, prev;
    logic        mo;
    int          len;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  32'(acc_valid), 32'd0);
    chk("rst_data", acc_data,       32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd1);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_ovf",  32'(overflow),  32'd0);
    rst_n = 1'b1;

    grp = '{32'h3F80_0000, 32'h4000_0000}; run_group("add",    32'h4040_0000, 1'b0);
    grp = '{32'h3F80_0000, 32'hBF80_0000}; run_group("cancel", 32'h0000_0000, 1'b0);
    grp = '{32'h3F80_0000, 32'h3380_0000}; run_group("tie",    32'h3F80_0000, 1'b0);
    grp = '{32'h3F80_0000, 32'h3380_0001}; run_group("rndup",  32'h3F80_0001, 1'b0);
    grp = '{32'h7F7F_FFFF, 32'h7F7F_FFFF}; run_group("ovfl",   32'h7F80_0000, 1'b1);
    grp = '{32'h7F80_0000, 32'hFF80_0000}; run_group("infinf", 32'h7FC0_0000, 1'b0);
    grp = '{32'h7FC0_0001, 32'h3F80_0000}; run_group("nan",    32'h7FC0_0000, 1'b0);
    grp = '{32'h0040_0000, 32'h3F80_0000}; run_group("denorm", 32'h3F80_0000, 1'b0);
    grp = '{32'h0080_0001, 32'h8080_0000}; run_group("uflow",  32'h0000_0000, 1'b0);
    grp = '{32'hC049_0FDB};                run_group("single", 32'hC049_0FDB, 1'b0);

    // clear in IDLE after a partial group, with a beat offered alongside
    beat(32'h4000_0000, 1'b0, 1'b1, "clr1", 32'h0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr1_noacc", 32'(busy), 32'd0);
    grp = '{32'h3F80_0000}; run_group("clr1_after", 32'h3F80_0000, 1'b0);

    // clear during ADD of a last beat: no result, sum restarts at zero
    in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr2_busy", 32'(busy),      32'd0);
    chk("clr2_rdy",  32'(in_ready),  32'd1);
    chk("clr2_vld",  32'(acc_valid), 32'd0);
    chk("clr2_data", acc_data,       last_acc);
    repeat (5) @(posedge clk);
    #1;
    grp = '{32'h3F80_0000}; run_group("clr2_after", 32'h3F80_0000, 1'b0);

    // random groups against the reference model
    for (int g = 0; g < 40; g++) begin
      grp.delete();
      prev = 32'h0;
      len  = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        prev = rnd_word(prev);
        grp.push_back(prev);
      end
      model_group(ms, mo);
      run_group($sformatf("rnd%0d", g), ms, mo);
    end

    // reset after a partial group: sum and outputs return to zero
    beat(32'h3F80_0000, 1'b0, 1'b1, "rst2", 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_data", acc_data,      32'd0);
    chk("rst2_busy", 32'(busy),     32'd0);
    chk("rst2_ovf",  32'(overflow), 32'd0);
    grp = '{32'h4000_0000}; run_group("rst2_after", 32'h4000_0000, 1'b0);

    chk("pulses", 32'(pulses), 32'(exp_pulses));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
